// File: rtl/muldiv_pkg.sv
// Shared constants, funct3 encodings and FSM state type for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = XLEN;
    localparam int unsigned ACC_W = 2 * XLEN + 1;
    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF       = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring-divide shift-subtract.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic             is_div,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [XLEN-1:0]  opb_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [XLEN:0]    sum;
    logic [XLEN:0]    trial;
    logic [ACC_W-1:0] shifted;

    // Multiply: {hi,lo} with multiplier in lo; divide: {remainder,dividend} shifted left each step.
    always_comb begin
        acc_o   = acc_i;
        sum     = '0;
        trial   = '0;
        shifted = '0;
        if (!is_div) begin
            sum = acc_i[ACC_W-1:XLEN] + {1'b0, opb_i};
            if (acc_i[0]) begin
                acc_o = {1'b0, sum, acc_i[XLEN-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[ACC_W-1:1]};
            end
        end else begin
            shifted = {acc_i[ACC_W-2:0], 1'b0};
            trial   = shifted[ACC_W-1:XLEN] - {1'b0, opb_i};
            if (!trial[XLEN]) begin
                acc_o = {trial, shifted[XLEN-1:1], 1'b1};
            end else begin
                acc_o = shifted;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer with pipeline stall and one-cycle done pulse.
// Optional feature macro: MULDIV_ZERO_SKIP_EN (zero-operand early completion).
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [2:0]       op_q, op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [XLEN-1:0]  opb_q, opb_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             sign_a, sign_b;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             special;
    logic [XLEN-1:0]  special_val;
    logic [ACC_W-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  quot, rem;
    logic [XLEN-1:0]  fix_result;

    muldiv_step u_step (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .opb_i  (opb_q),
        .acc_o  (step_acc)
    );

    // Operand signs/magnitudes and early-completion results decoded from the incoming request.
    always_comb begin
        sign_a      = rs1[XLEN-1] && ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                                      (funct3 == F3_DIV)  || (funct3 == F3_REM));
        sign_b      = rs2[XLEN-1] && ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                                      (funct3 == F3_REM));
        abs_a       = sign_a ? (~rs1 + XLEN'(1)) : rs1;
        abs_b       = sign_b ? (~rs2 + XLEN'(1)) : rs2;
        special     = 1'b0;
        special_val = '0;
        if (funct3[2] && (rs2 == '0)) begin
            special     = 1'b1;
            special_val = funct3[1] ? rs1 : DIV0_QUOT;
        end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) && (rs1 == OVF) && (rs2 == '1)) begin
            special     = 1'b1;
            special_val = funct3[1] ? '0 : OVF;
        end
`ifdef MULDIV_ZERO_SKIP_EN
        else if ((!funct3[2] && ((rs1 == '0) || (rs2 == '0))) || (funct3[2] && (rs1 == '0))) begin
            special     = 1'b1;
            special_val = '0;
        end
`endif
    end

    // Sign correction and word selection applied in FIX.
    always_comb begin
        prod = acc_q[2*XLEN-1:0];
        if (neg_res_q) prod = ~prod + (2*XLEN)'(1);
        quot = acc_q[XLEN-1:0];
        if (neg_res_q) quot = ~quot + XLEN'(1);
        rem = acc_q[2*XLEN-1:XLEN];
        if (neg_rem_q) rem = ~rem + XLEN'(1);
        if (op_q[2]) begin
            fix_result = op_q[1] ? rem : quot;
        end else begin
            fix_result = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Next-state, datapath updates and stall.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        result_d  = result_q;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = start & ~flush;
                if (start && !flush) begin
                    op_d      = funct3;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    counter_d = '0;
                    acc_d     = {{(XLEN+1){1'b0}}, (funct3[2] ? abs_a : abs_b)};
                    opb_d     = funct3[2] ? abs_b : abs_a;
                    if (special) begin
                        result_d = special_val;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d     = step_acc;
                    counter_d = counter_q + CNT_W'(1);
                    if (counter_q == CNT_W'(ITER - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops against an arithmetic model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural result of an RV32M op from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'h0, b});
        up = {32'h0, a} * {32'h0, b};
        case (f3)
            3'b000: return up[31:0];
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: return up[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept to done.
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
        if (!f3[2] && (a == 0 || b == 0)) return 1;
        if (f3[2] && a == 0) return 1;
`endif
        return 34;
    endfunction

    // Issue one op and check stall profile, latency, result and the single-cycle done pulse.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string tag,
                          input bit start_in_done);
        int lat;
        bit stall_ok;
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        #1 check({tag, "_stall_accept"}, 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = -1;
        stall_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (done) begin lat = c; break; end
            if (!(stall && busy)) stall_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        check({tag, "_stall_while_busy"}, 32'(stall_ok), 32'd1);
        if (start_in_done) begin
            start = 1'b1; funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        check({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] a, b;
        logic [2:0]  f;
        int          seen_done;

        // Reset state
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed multiply/divide cases
        run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7xm3", 1'b0);
        run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max", 1'b0);
        run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_m1m1", 1'b0);
        run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, "mulhsu_m1x2", 1'b0);
        run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "div_m7_2", 1'b1);
        run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2", 1'b0);
        run_op(F3_DIVU,   32'd100,        32'd7,         32'd14,        34, "divu_100_7", 1'b0);
        run_op(F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu_by0", 1'b0);
        run_op(F3_REM,    32'd5,          32'd0,         32'd5,         1,  "rem_by0", 1'b0);
        run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf", 1'b1);
        run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf", 1'b0);
        run_op(F3_REMU,   32'd100,        32'd7,         32'd2,         34, "remu_100_7", 1'b0);

        // Flush during RUN
        prev = result;
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIV; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1 check("flush_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, prev);
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done) seen_done++;
        end
        check("flush_no_done", 32'(seen_done), 32'd0);

        // start and flush together in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = F3_MUL; rs1 = 32'd9; rs2 = 32'd9;
        #1 check("startflush_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check("startflush_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-multiply
        @(negedge clk);
        start = 1'b1; funct3 = F3_MUL; rs1 = 32'd123; rs2 = 32'd456;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F3_MUL, 32'd123, 32'd456, 32'd56088, 34, "mul_after_rst", 1'b0);
        run_op(F3_MUL, 32'd0, 32'd5, 32'd0, ref_latency(F3_MUL, 32'd0, 32'd5), "mul_zero", 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: a = 32'h0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(f, a, b, ref_model(f, a, b), ref_latency(f, a, b), "rand", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M extension. Sits beside the EX-stage ALU.
- Accepts one MUL/DIV-class operation from EX and stalls the pipeline while it iterates. Uses shift-add for multiply and restoring division for divide.
- Returns a 32-bit result with a one-cycle done pulse. The ALU's own operation selection is unchanged; this block owns only funct7=0000001 R-type ops.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, iteration count (equals XLEN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid M-extension instruction.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (dividend).
- rs2  in  XLEN  operand B (divisor).
- flush  in  1  branch/jump flush of EX.
- stall  out  1  freeze IF/ID/EX pipeline registers.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; result is valid.
- result  out  XLEN  operation result, held until the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers cleared. Reset mid-operation aborts with no done.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3, latch sign flags and absolute values per op signedness (MULH: both signed; MULHSU: rs1 only; DIV/REM: both), counter=0.
  - Go to DONE for special cases, else RUN.
  - stall=start&~flush combinationally in this cycle.
- Special cases, resolved in IDLE; DONE is reached in cycle 1:
  - Divisor zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU=rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): DIV=0x80000000, REM=0.
- RUN: one iteration per cycle, counter 0..ITER-1; at counter=ITER-1 go to FIX. stall=1.
  - Multiply: 64-bit accumulator; add multiplicand if multiplier LSB=1, shift right.
  - Divide: shift remainder:dividend left, subtract divisor if non-negative, set quotient bit.
- FIX: one cycle; stall=1.
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Select low word (MUL, DIV*, REM*) or high word (MULH*). Register into result. Go to DONE.
- DONE: done=1, stall=0 so the pipeline advances and captures result. Next state IDLE.
  - start in DONE is ignored; a new op is accepted only in IDLE.
- Latency, with the accept cycle as 0: normal ops RUN cycles 1–32, FIX cycle 33, done at cycle 34. Special cases done at cycle 1.
- flush:
  - In RUN/FIX: next state IDLE, no done, result unchanged.
  - Same cycle as start in IDLE: flush wins, nothing accepted.
  - In DONE: ignored (the op has already retired).
- start while not IDLE is ignored; operands are captured only at accept.
- All arithmetic is unsigned on magnitudes; the accumulator is 2*XLEN+1 bits to hold the subtract borrow.

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined: if either multiply operand is 0, or the dividend is 0 with a nonzero divisor, go IDLE→DONE with result=0 (REM* result=0). done at cycle 1.
- Undefined: these operands take the full 34-cycle path, giving identical results.

Decomposition:
- Package muldiv_pkg: XLEN/ITER constants, funct3 encodings as named localparams, the state encoding (2 bits), and the DIV0_QUOT and OVF constants.
- One natural sub-module, muldiv_step: purely combinational single-iteration datapath (mul add-shift / div shift-subtract, selected by an is_div input). The sequencer holds all registers and the FSM.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → done at cycle 34, result=0xFFFFFFEB; stall high cycles 0–33, low at 34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF at cycle 1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0, both at cycle 1.
- flush asserted at cycle 10 of a DIV → state IDLE at cycle 11, busy=0, stall=0, no done pulse, result keeps its previous value; a start+flush pair in IDLE → not accepted.
- rst_n low at cycle 20 of a MUL → busy/done/result=0 immediately (asynchronous). A new MUL after release completes normally; with MULDIV_ZERO_SKIP_EN, MUL 0×5 → done at cycle 1, result 0.
